// File: rtl/gun_aim_pkg.sv
// Shared types, tuning constants and position clamp for the gun aim arbiter.
package gun_aim_pkg;

    localparam int POS_MAX     = 63;
    localparam int HOLD_TICKS  = 3;
    localparam int DEADZONE    = 16;
    localparam int MOUSE_SHIFT = 3;
    localparam int LOCK_TICKS  = 250;

    localparam logic [5:0] POS_CENTRE = 6'((POS_MAX + 1) / 2);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DIG  = 2'd1,
        SRC_ANA  = 2'd2,
        SRC_MOU  = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_STEP_H = 2'd2,
        ST_STEP_V = 2'd3
    } state_t;

    function automatic logic [5:0] clamp_pos(input logic signed [7:0] v);
        if (v < 8'sd0)
            return 6'd0;
        else if (v > $signed(8'(POS_MAX)))
            return 6'(POS_MAX);
        else
            return v[5:0];
    endfunction

endpackage

// File: rtl/gun_aim_mouse_acc.sv
// Per-axis saturating mouse accumulator; a consume hands out whole steps
// and keeps the sub-step remainder, so a same-cycle strobe is never lost.
module gun_aim_mouse_acc
    import gun_aim_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              stb,
    input  logic signed [8:0] delta,
    input  logic              consume,
    input  logic              clear,
    output logic signed [8:0] steps,
    output logic              req
);

    localparam logic signed [12:0] ACC_HI = 13'sd2047;
    localparam logic signed [12:0] ACC_LO = -13'sd2047;

    logic signed [11:0] acc;
    logic signed [11:0] base;
    logic signed [12:0] sum;
    logic signed [11:0] acc_n;

    assign steps = 9'(acc >>> MOUSE_SHIFT);
    assign req   = (acc != 12'sd0);

    always_comb begin
        base = acc;
        if (consume)
            base = $signed(12'(acc[MOUSE_SHIFT-1:0]));
        sum   = 13'(base) + 13'(delta);
        acc_n = base;
        if (stb) begin
            if (sum > ACC_HI)
                acc_n = 12'sd2047;
            else if (sum < ACC_LO)
                acc_n = -12'sd2047;
            else
                acc_n = sum[11:0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else
            acc <= acc_n;
    end

endmodule

// File: rtl/gun_aim_arbiter.sv
// Gun aim position owner: arbitrates joystick, analog and mouse once per 4 ms tick.
// Optional GUN_AIM_RECENTER_EN adds a recenter level input that wins over all sources.
module gun_aim_arbiter
    import gun_aim_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              tick_4ms,
    input  logic [3:0]        joy_dir,
    input  logic signed [7:0] ana_x,
    input  logic signed [7:0] ana_y,
    input  logic              mouse_stb,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    input  logic [1:0]        src_sel,
`ifdef GUN_AIM_RECENTER_EN
    input  logic              recenter,
`endif
    output logic [5:0]        gun_h,
    output logic [5:0]        gun_v,
    output logic [1:0]        owner,
    output logic              upd
);

    localparam int CW = $clog2(HOLD_TICKS);

    state_t            state, state_n;
    src_t              own, own_n;
    logic              tick_q, tick_edge;
    logic [7:0]        lock, lock_n;
    logic [CW-1:0]     cnt_h, cnt_v, cnt_h_n, cnt_v_n;
    logic [5:0]        gun_h_n, gun_v_n;
    logic              chg, chg_n, upd_n;
    logic              clear, recentre;
    logic              dig_req, ana_req, mou_req, mreq_h, mreq_v;
    logic [3:0]        req;
    logic signed [8:0] steps_h, steps_v, d_h, d_v;
    logic [5:0]        tgt_h, tgt_v;

`ifdef GUN_AIM_RECENTER_EN
    assign recentre = recenter;
`else
    assign recentre = 1'b0;
`endif

    function automatic logic ana_big(input logic signed [7:0] v);
        logic [7:0] m;
        m = v[7] ? 8'(-v) : 8'(v);
        return m >= 8'(DEADZONE);
    endfunction

    function automatic logic [CW-1:0] cnt_next(input src_t s, input logic neg,
                                               input logic pos, input logic [CW-1:0] c);
        if (s != SRC_DIG || !(neg ^ pos))
            return '0;
        if (c == CW'(HOLD_TICKS - 1))
            return '0;
        return c + CW'(1);
    endfunction

    // Joystick steps on hold count 1; analog only moves while outside the deadzone.
    function automatic logic signed [8:0] axis_delta(
        input src_t s, input logic neg, input logic pos, input logic [CW-1:0] c,
        input logic [5:0] p, input logic [5:0] tgt, input logic areq,
        input logic signed [8:0] msteps);
        logic signed [8:0] d;
        d = '0;
        unique case (s)
            SRC_DIG: if ((neg ^ pos) && c == CW'(1)) d = pos ? 9'sd1 : -9'sd1;
            SRC_ANA: if (areq && tgt > p) d = 9'sd1;
                     else if (areq && tgt < p) d = -9'sd1;
            SRC_MOU: d = msteps;
            default: d = '0;
        endcase
        return d;
    endfunction

    // Delta is limited to +/-64 first so the sum fits 8-bit signed exactly.
    function automatic logic [5:0] move(input logic [5:0] p, input logic signed [8:0] d);
        logic signed [7:0] dd;
        if (d > 9'sd64)
            dd = 8'sd64;
        else if (d < -9'sd64)
            dd = -8'sd64;
        else
            dd = d[7:0];
        return clamp_pos($signed({2'b00, p}) + dd);
    endfunction

    assign dig_req = |joy_dir;
    assign ana_req = ana_big(ana_x) | ana_big(ana_y);
    assign mou_req = mreq_h | mreq_v;
    assign req     = {mou_req, ana_req, dig_req, 1'b0};
    assign tgt_h   = {~ana_x[7], ana_x[6:2]};
    assign tgt_v   = {~ana_y[7], ana_y[6:2]};
    assign owner   = own;

    assign d_h = axis_delta(own, joy_dir[1], joy_dir[0], cnt_h, gun_h, tgt_h, ana_req, steps_h);
    assign d_v = axis_delta(own, joy_dir[3], joy_dir[2], cnt_v, gun_v, tgt_v, ana_req, steps_v);

    gun_aim_mouse_acc u_acc_h (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .stb     (mouse_stb),
        .delta   (mouse_dx),
        .consume (state == ST_STEP_H && own == SRC_MOU),
        .clear   (clear),
        .steps   (steps_h),
        .req     (mreq_h)
    );

    gun_aim_mouse_acc u_acc_v (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .stb     (mouse_stb),
        .delta   (mouse_dy),
        .consume (state == ST_STEP_V && own == SRC_MOU),
        .clear   (clear),
        .steps   (steps_v),
        .req     (mreq_v)
    );

    always_comb begin
        state_n = state;
        own_n   = own;
        lock_n  = lock;
        cnt_h_n = cnt_h;
        cnt_v_n = cnt_v;
        gun_h_n = gun_h;
        gun_v_n = gun_v;
        chg_n   = chg;
        upd_n   = 1'b0;
        clear   = 1'b0;
        unique case (state)
            ST_IDLE: if (tick_edge) state_n = ST_ARB;
            ST_ARB: begin
                state_n = ST_STEP_H;
                chg_n   = 1'b0;
                if (recentre) begin
                    own_n   = SRC_NONE;
                    lock_n  = '0;
                    clear   = 1'b1;
                    gun_h_n = POS_CENTRE;
                    gun_v_n = POS_CENTRE;
                    chg_n   = 1'b1;
                end else begin
                    if (src_sel != 2'd0) begin
                        if (req[src_sel])
                            own_n = src_t'(src_sel);
                        else if (own != src_t'(src_sel))
                            own_n = SRC_NONE;
                    end else if (!req[own]) begin
                        if (mou_req)
                            own_n = SRC_MOU;
                        else if (ana_req)
                            own_n = SRC_ANA;
                        else if (dig_req)
                            own_n = SRC_DIG;
                    end
                    if (req[own_n]) begin
                        lock_n = '0;
                    end else begin
                        if (lock != 8'(LOCK_TICKS))
                            lock_n = lock + 8'd1;
                        if (lock_n == 8'(LOCK_TICKS))
                            own_n = SRC_NONE;
                    end
                    clear = (own_n != own) && (own_n != SRC_NONE) && (own_n != SRC_MOU);
                end
            end
            ST_STEP_H: begin
                state_n = ST_STEP_V;
                gun_h_n = move(gun_h, d_h);
                cnt_h_n = cnt_next(own, joy_dir[1], joy_dir[0], cnt_h);
                chg_n   = chg | (gun_h_n != gun_h);
            end
            ST_STEP_V: begin
                state_n = ST_IDLE;
                gun_v_n = move(gun_v, d_v);
                cnt_v_n = cnt_next(own, joy_dir[3], joy_dir[2], cnt_v);
                upd_n   = chg | (gun_v_n != gun_v);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tick_q    <= 1'b0;
            tick_edge <= 1'b0;
            own       <= SRC_NONE;
            lock      <= '0;
            cnt_h     <= '0;
            cnt_v     <= '0;
            gun_h     <= POS_CENTRE;
            gun_v     <= POS_CENTRE;
            chg       <= 1'b0;
            upd       <= 1'b0;
        end else begin
            state     <= state_n;
            tick_q    <= tick_4ms;
            tick_edge <= tick_4ms & ~tick_q;
            own       <= own_n;
            lock      <= lock_n;
            cnt_h     <= cnt_h_n;
            cnt_v     <= cnt_v_n;
            gun_h     <= gun_h_n;
            gun_v     <= gun_v_n;
            chg       <= chg_n;
            upd       <= upd_n;
        end
    end

endmodule

// File: tb/tb_gun_aim_arbiter.sv
// Bench for gun_aim_arbiter: directed scenarios plus random ticks vs a tick-level model.
module tb_gun_aim_arbiter;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              tick_4ms;
    logic [3:0]        joy_dir;
    logic signed [7:0] ana_x, ana_y;
    logic              mouse_stb;
    logic signed [8:0] mouse_dx, mouse_dy;
    logic [1:0]        src_sel;
    logic [5:0]        gun_h, gun_v;
    logic [1:0]        owner;
    logic              upd;
`ifdef GUN_AIM_RECENTER_EN
    logic              recenter = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;
    int m_h, m_v, m_own, m_lock, m_acc_h, m_acc_v, m_cnt_h, m_cnt_v;

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (upd) upd_cnt++;

    gun_aim_arbiter dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .tick_4ms  (tick_4ms),
        .joy_dir   (joy_dir),
        .ana_x     (ana_x),
        .ana_y     (ana_y),
        .mouse_stb (mouse_stb),
        .mouse_dx  (mouse_dx),
        .mouse_dy  (mouse_dy),
        .src_sel   (src_sel),
`ifdef GUN_AIM_RECENTER_EN
        .recenter  (recenter),
`endif
        .gun_h     (gun_h),
        .gun_v     (gun_v),
        .owner     (owner),
        .upd       (upd)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int sat_acc(input int a);
        if (a > 2047) return 2047;
        if (a < -2047) return -2047;
        return a;
    endfunction

    function automatic int floor_div8(input int a);
        int q;
        q = a / 8;
        if ((a % 8) != 0 && a < 0) q--;
        return q;
    endfunction

    task automatic model_reset();
        m_h = 32; m_v = 32; m_own = 0; m_lock = 0;
        m_acc_h = 0; m_acc_v = 0; m_cnt_h = 0; m_cnt_v = 0;
    endtask

    task automatic axis(input int src, input bit neg, input bit pos, input int val,
                        input bit areq, inout int cnt, inout int acc, inout int p);
        int d, tgt;
        d = 0;
        if (src == 1 && neg != pos) begin
            if (cnt == 1) d = pos ? 1 : -1;
            cnt = (cnt + 1) % 3;
        end else begin
            cnt = 0;
        end
        if (src == 2 && areq) begin
            tgt = (val + 128) / 4;
            d = (tgt > p) ? 1 : (tgt < p) ? -1 : 0;
        end
        if (src == 3) begin
            d = floor_div8(acc);
            acc = acc - d * 8;
        end
        p = p + d;
        if (p < 0) p = 0;
        if (p > 63) p = 63;
    endtask

    task automatic model_tick(output bit exp_upd);
        int req[4];
        int nown, oh, ov, sel;
        sel = int'(src_sel);
        req[0] = 0;
        req[1] = int'(joy_dir != 4'd0);
        req[2] = int'(iabs(int'(ana_x)) >= 16 || iabs(int'(ana_y)) >= 16);
        req[3] = int'(m_acc_h != 0 || m_acc_v != 0);
        nown = m_own;
        if (sel != 0) begin
            if (req[sel] != 0) nown = sel;
            else if (m_own != sel) nown = 0;
        end else if (req[m_own] == 0) begin
            if (req[3] != 0) nown = 3;
            else if (req[2] != 0) nown = 2;
            else if (req[1] != 0) nown = 1;
        end
        if (nown != 0 && req[nown] != 0) begin
            m_lock = 0;
        end else begin
            if (m_lock < 250) m_lock++;
            if (m_lock == 250) nown = 0;
        end
        if (nown != m_own && nown != 0 && nown != 3) begin
            m_acc_h = 0;
            m_acc_v = 0;
        end
        m_own = nown;
        oh = m_h;
        ov = m_v;
        axis(m_own, joy_dir[1], joy_dir[0], int'(ana_x), req[2] != 0, m_cnt_h, m_acc_h, m_h);
        axis(m_own, joy_dir[3], joy_dir[2], int'(ana_y), req[2] != 0, m_cnt_v, m_acc_v, m_v);
        exp_upd = (m_h != oh) || (m_v != ov);
    endtask

    task automatic mouse_in(input int dx, input int dy);
        @(negedge clk_sys);
        mouse_stb = 1'b1;
        mouse_dx  = 9'(dx);
        mouse_dy  = 9'(dy);
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        mouse_dx  = '0;
        mouse_dy  = '0;
        m_acc_h = sat_acc(m_acc_h + dx);
        m_acc_v = sat_acc(m_acc_v + dy);
    endtask

    // stb_dx != 0 drives a mouse strobe during the horizontal consume cycle.
    task automatic tick_core(input string tag, input int stb_dx);
        bit eu;
        int u0;
        model_tick(eu);
        if (stb_dx != 0) m_acc_h = sat_acc(m_acc_h + stb_dx);
        u0 = upd_cnt;
        @(negedge clk_sys);
        tick_4ms = 1'b1;
        repeat (3) @(negedge clk_sys);
        if (stb_dx != 0) begin
            mouse_stb = 1'b1;
            mouse_dx  = 9'(stb_dx);
        end
        @(negedge clk_sys);
        mouse_stb = 1'b0;
        mouse_dx  = '0;
        repeat (4) @(negedge clk_sys);
        tick_4ms = 1'b0;
        repeat (2) @(negedge clk_sys);
        check({tag, ".h"}, int'(gun_h), m_h);
        check({tag, ".v"}, int'(gun_v), m_v);
        check({tag, ".own"}, int'(owner), m_own);
        check({tag, ".upd"}, upd_cnt - u0, int'(eu));
    endtask

    task automatic do_tick(input string tag);
        tick_core(tag, 0);
    endtask

    initial begin
        int h0, u0, hold;
        reset_n   = 1'b0;
        tick_4ms  = 1'b0;
        joy_dir   = '0;
        ana_x     = '0;
        ana_y     = '0;
        mouse_stb = 1'b0;
        mouse_dx  = '0;
        mouse_dy  = '0;
        src_sel   = '0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("rst.h", int'(gun_h), 32);
        check("rst.v", int'(gun_v), 32);
        check("rst.own", int'(owner), 0);
        check("rst.upd", int'(upd), 0);

        joy_dir = 4'b0001;
        u0 = upd_cnt;
        for (int i = 0; i < 10; i++) do_tick("right");
        check("right.h35", int'(gun_h), 35);
        check("right.upd3", upd_cnt - u0, 3);

        joy_dir = 4'b0010;
        for (int i = 0; i < 120; i++) do_tick("left");
        check("left.clamp0", int'(gun_h), 0);
        joy_dir = 4'b0011;
        for (int i = 0; i < 6; i++) do_tick("lr");
        check("lr.hold0", int'(gun_h), 0);

        joy_dir = 4'b0001;
        do_tick("dig");
        mouse_in(16, 0);
        do_tick("dig_m1");
        check("dig_keep1", int'(owner), 1);
        do_tick("dig_m2");
        check("dig_keep2", int'(owner), 1);
        joy_dir = 4'b0000;
        h0 = m_h;
        do_tick("mou_take");
        check("mou_own", int'(owner), 3);
        check("mou_h+2", int'(gun_h), h0 + 2);
        do_tick("mou_acc0");
        check("mou_idle", int'(gun_h), h0 + 2);

        joy_dir = 4'b0100;
        do_tick("lock_dig");
        joy_dir = 4'b0000;
        for (int i = 1; i <= 250; i++) begin
            do_tick("lock");
            if (i == 249) check("lock249", int'(owner), 1);
        end
        check("lock250", int'(owner), 0);

        ana_x = 8'sd127;
        h0 = m_h;
        for (int i = 0; i < 5; i++) do_tick("ana");
        check("ana_rise5", int'(gun_h), h0 + 5);
        ana_x = 8'sd10;
        h0 = m_h;
        for (int i = 0; i < 3; i++) do_tick("ana_dz");
        check("ana_dz_hold", int'(gun_h), h0);

        ana_x = 8'sd0;
        mouse_in(11, 0);
        h0 = m_h;
        tick_core("coin", 5);
        check("coin_h+1", int'(gun_h), h0 + 1);
        do_tick("coin_rem");
        check("coin_rem_h+2", int'(gun_h), h0 + 2);

        mouse_in(16, 0);
        @(negedge clk_sys);
        tick_4ms = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset_n  = 1'b0;
        tick_4ms = 1'b0;
        #1;
        check("midrst.h", int'(gun_h), 32);
        check("midrst.v", int'(gun_v), 32);
        check("midrst.own", int'(owner), 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_sys);
        check("midrst.keep", int'(gun_h), 32);

        for (int n = 0; n < 80; n++) begin
            joy_dir = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
            ana_x   = ($urandom_range(0, 1) == 0) ? 8'sd0 : 8'($urandom_range(0, 255));
            ana_y   = ($urandom_range(0, 1) == 0) ? 8'sd0 : 8'($urandom_range(0, 255));
            src_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            hold    = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 9) < 3)
                    mouse_in(int'($urandom_range(0, 511)) - 256,
                             int'($urandom_range(0, 511)) - 256);
                do_tick("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
